// File: rtl/hop_ctrl.sv
// Hop button conditioner: sync + debounce + one-shot hop FSM driving move_btn.
// Optional macro HOP_CTRL_AUTOREPEAT_EN enables auto-repeat while the button is held.
module hop_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOP_CYCLES      = 2000010,
    parameter int COOLDOWN_CYCLES = 125000,
    parameter int REPEAT_CYCLES   = 500000,
    parameter int CNT_W           = 21
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    output logic       move_btn,
    output logic       busy,
    output logic       btn_db,
    output logic [7:0] hop_count
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] HOP      = 2'd1;
    localparam logic [1:0] COOLDOWN = 2'd2;
    localparam logic [1:0] WAIT_REL = 2'd3;

`ifdef HOP_CTRL_AUTOREPEAT_EN
    localparam logic AUTOREP = 1'b1;
`else
    localparam logic AUTOREP = 1'b0;
`endif

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOP_LAST  = CNT_W'(HOP_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic             sync1, btn_s;
    logic [CNT_W-1:0] db_cnt;
    logic             btn_db_d, press;
    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] phase_cnt, phase_nxt;
    logic             hop_start;

    always_comb begin
        state_nxt = state;
        phase_nxt = phase_cnt;
        hop_start = 1'b0;
        case (state)
            IDLE: begin
                if (press) begin
                    state_nxt = HOP;
                    phase_nxt = '0;
                    hop_start = 1'b1;
                end
            end
            HOP: begin
                if (phase_cnt == HOP_LAST) begin
                    state_nxt = COOLDOWN;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase_cnt + CNT_W'(1);
                end
            end
            COOLDOWN: begin
                if (phase_cnt == COOL_LAST) begin
                    state_nxt = btn_db ? WAIT_REL : IDLE;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase_cnt + CNT_W'(1);
                end
            end
            WAIT_REL: begin
                // Without auto-repeat this state only waits for release.
                if (!btn_db) begin
                    state_nxt = IDLE;
                    phase_nxt = '0;
                end else if (AUTOREP && phase_cnt == REP_LAST) begin
                    state_nxt = HOP;
                    phase_nxt = '0;
                    hop_start = 1'b1;
                end else if (AUTOREP) begin
                    phase_nxt = phase_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                phase_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 1'b0;
            btn_s     <= 1'b0;
            db_cnt    <= '0;
            btn_db    <= 1'b0;
            btn_db_d  <= 1'b0;
            press     <= 1'b0;
            state     <= IDLE;
            phase_cnt <= '0;
            move_btn  <= 1'b0;
            busy      <= 1'b0;
            hop_count <= 8'd0;
        end else begin
            sync1 <= btn_raw;
            btn_s <= sync1;
            // Only an unbroken run of mismatching samples flips the debounced level.
            if (btn_s != btn_db) begin
                if (db_cnt == DB_LAST) begin
                    btn_db <= ~btn_db;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + CNT_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
            btn_db_d  <= btn_db;
            press     <= btn_db & ~btn_db_d;
            state     <= state_nxt;
            phase_cnt <= phase_nxt;
            move_btn  <= (state_nxt == HOP);
            busy      <= (state_nxt != IDLE);
            hop_count <= hop_count + {7'd0, hop_start};
        end
    end

endmodule

// File: tb/tb_hop_ctrl.sv
// Bench for hop_ctrl: directed scenarios plus random button activity, all checked
// every cycle against a timestamp-based reference model of hop timing.
module tb_hop_ctrl;
    localparam int DB = 4, HC = 10, CC = 3, RC = 5;
`ifdef HOP_CTRL_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_raw = 1'b0;
    logic       move_btn, busy, btn_db;
    logic [7:0] hop_count;

    hop_ctrl #(.DEBOUNCE_CYCLES(DB), .HOP_CYCLES(HC), .COOLDOWN_CYCLES(CC),
               .REPEAT_CYCLES(RC), .CNT_W(21)) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .move_btn(move_btn), .busy(busy), .btn_db(btn_db), .hop_count(hop_count)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: sync delay line, run-length debounce, and hop phases
    // derived from the edge index at which the current hop started.
    bit m_s1, m_s2, m_db, m_dbd, m_press, m_act;
    int m_cnt, m_T, m_n, m_hops;

    task automatic model_edge();
        int  e;
        bit  np;
        m_n++;
        if (reset) begin
            {m_s1, m_s2, m_db, m_dbd, m_press, m_act} = '0;
            m_cnt = 0; m_hops = 0;
            return;
        end
        if (!m_act) begin
            if (m_press) begin m_act = 1; m_T = m_n; m_hops++; end
        end else begin
            e = m_n - m_T;
            if (e == HC + CC) m_act = m_db;
            else if (e > HC + CC) begin
                if (!m_db) m_act = 0;
                else if (AR && e == HC + CC + RC) begin m_T = m_n; m_hops++; end
            end
        end
        np = m_db & ~m_dbd;
        m_dbd = m_db;
        m_press = np;
        if (m_s2 != m_db) begin
            if (m_cnt == DB - 1) begin m_db = ~m_db; m_cnt = 0; end
            else m_cnt++;
        end else m_cnt = 0;
        m_s2 = m_s1;
        m_s1 = btn_raw;
    endtask

    task automatic step();
        bit mv;
        @(posedge clk);
        model_edge();
        #1;
        mv = m_act && ((m_n - m_T) < HC);
        chk("outs", {21'd0, move_btn, busy, btn_db, hop_count},
            {21'd0, mv, m_act, m_db, 8'(m_hops)});
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
    endtask

    initial begin
        int rise, mv, n;
        bit anydb;

        // Reset with the button held
        btn_raw = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_outs", {move_btn, busy, btn_db, hop_count}, 11'd0);
        end
        btn_raw = 1'b0;
        reset = 1'b0;
        repeat (10) step();

        // Single long press
        do_reset(2);
        btn_raw = 1'b1;
        rise = -1; mv = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (btn_db && rise < 0) rise = i;
            mv += move_btn;
        end
        chk("db_rise", rise, 6);
        chk("move_len", mv, 10);
        chk("hops_one", hop_count, 1);
        chk("wait_rel_busy", busy, 1);
        btn_raw = 1'b0;
        repeat (10) step();
        chk("busy_released", busy, 0);

        // Short glitches never debounce
        do_reset(2);
        anydb = 0;
        for (int w = 1; w <= 3; w++) begin
            btn_raw = 1'b1;
            for (int k = 0; k < w; k++) begin step(); anydb |= btn_db; end
            btn_raw = 1'b0;
            for (int k = 0; k < 5; k++) begin step(); anydb |= btn_db; end
        end
        repeat (5) begin step(); anydb |= btn_db; end
        chk("glitch_db", anydb, 0);
        chk("glitch_hops", hop_count, 0);

        // Press landing in cooldown is ignored
        do_reset(2);
        btn_raw = 1'b1; repeat (6) step();
        btn_raw = 1'b0; repeat (6) step();
        btn_raw = 1'b1; repeat (6) step();
        btn_raw = 1'b0; repeat (20) step();
        chk("cool_press_hops", hop_count, 1);
        chk("cool_press_idle", busy, 0);
        btn_raw = 1'b1; repeat (8) step();
        btn_raw = 1'b0; repeat (25) step();
        chk("second_hop", hop_count, 2);

        // Reset in the middle of a hop
        do_reset(2);
        btn_raw = 1'b1;
        n = 0;
        while (!move_btn && n < 50) begin step(); n++; end
        if (n >= 50) chk("hop_timeout", 0, 1);
        repeat (5) step();
        chk("mid_hop_move", move_btn, 1);
        reset = 1'b1;
        step();
        chk("abort_move", move_btn, 0);
        chk("abort_busy", busy, 0);
        chk("abort_hops", hop_count, 0);
        reset = 1'b0;
        btn_raw = 1'b0;
        repeat (10) step();

        // Held button: auto-repeat or single hop
        do_reset(2);
        btn_raw = 1'b1; repeat (100) step();
        chk("hold_hops", hop_count, AR ? 6 : 1);
        btn_raw = 1'b0; repeat (30) step();

        // 256 presses wrap the counter
        do_reset(2);
        for (int i = 0; i < 256; i++) begin
            btn_raw = 1'b1; repeat (8) step();
            btn_raw = 1'b0; repeat (20) step();
            if (i == 254) chk("pre_wrap", hop_count, 255);
        end
        chk("wrap", hop_count, 0);

        // Random button activity with occasional resets
        do_reset(2);
        for (int seg = 0; seg < 120; seg++) begin
            if ($urandom_range(0, 40) == 0) do_reset(1);
            btn_raw = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 45)) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
